// File: rtl/icache_2way_if.sv
// Fetch-side and refill-side bus of the two-way instruction cache.
// master: fetch unit plus instruction memory (drives pc_address/read and the refill return).
// slave : the cache (drives busywait/readdata and the refill request).
interface icache_2way_if #(
   parameter int ADDR_W    = 10,
   parameter int WOFF_BITS = 2
);
   localparam int BLK_W   = 32 << WOFF_BITS;
   localparam int BADDR_W = ADDR_W - 2 - WOFF_BITS;

   // fetch side
   logic [ADDR_W-1:0]  pc_address;
   logic               read;
   logic               busywait;
   logic [31:0]        readdata;
   // refill side
   logic               mem_read;
   logic [BADDR_W-1:0] mem_address;
   logic [BLK_W-1:0]   mem_readdata;
   logic               mem_busywait;

   modport master (
      output pc_address, read, mem_readdata, mem_busywait,
      input  busywait, readdata, mem_read, mem_address
   );

   modport slave (
      input  pc_address, read, mem_readdata, mem_busywait,
      output busywait, readdata, mem_read, mem_address
   );
endinterface

// File: rtl/icache_2way.sv
// Two-way set-associative instruction cache with per-set LRU, whole-cache flush and saturating counters.
// Latency: hits return data combinationally (0 stall); a miss stalls N+3 cycles (N = memory busy cycles).
// Backpressure: busywait stalls the fetch unit; mem_busywait holds the cache in MEM_READ until the block arrives.
// Ports: clock, reset (sync, active-high), flush, bus (icache_2way_if.slave), hit_count, miss_count.
module icache_2way #(
   parameter int ADDR_W     = 10,
   parameter int WOFF_BITS  = 2,
   parameter int INDEX_BITS = 2,
   parameter int CNT_W      = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   icache_2way_if.slave     bus,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);
   localparam int BLK_W   = 32 << WOFF_BITS;
   localparam int SETS    = 1 << INDEX_BITS;
   localparam int TAG_W   = ADDR_W - 2 - WOFF_BITS - INDEX_BITS;
   localparam int BADDR_W = ADDR_W - 2 - WOFF_BITS;

   typedef enum logic [1:0] {IDLE, MEM_READ, C_UPDATE} state_t;

   state_t              state_q;
   logic [SETS-1:0]     valid_q [2];
   logic [SETS-1:0]     lru_q;          // names the least-recently-used way of each set
   logic [TAG_W-1:0]    tag_q   [2][SETS];
   logic [BLK_W-1:0]    data_q  [2][SETS];
   logic                victim_q;
   logic                flush_pending_q;
   logic                mem_read_q;
   logic [BADDR_W-1:0]  mem_addr_q;
   logic [CNT_W-1:0]    hit_count_q, miss_count_q;
   logic [CNT_W-1:0]    hit_count_d, miss_count_d;

   // address split
   logic [WOFF_BITS-1:0]  woff;
   logic [INDEX_BITS-1:0] idx;
   logic [TAG_W-1:0]      tag;
   logic                  unused_pc;
   assign woff      = bus.pc_address[2 +: WOFF_BITS];
   assign idx       = bus.pc_address[2+WOFF_BITS +: INDEX_BITS];
   assign tag       = bus.pc_address[ADDR_W-1 -: TAG_W];
   assign unused_pc = ^bus.pc_address[1:0];

   // combinational lookup
   logic [1:0]       hit_w;
   logic             hit;
   logic             hit_ok;
   logic             victim;
   logic [BLK_W-1:0] blk_sel;
   assign hit_w[0] = valid_q[0][idx] && (tag_q[0][idx] == tag);
   assign hit_w[1] = valid_q[1][idx] && (tag_q[1][idx] == tag);
   assign hit      = |hit_w;
   assign blk_sel  = hit_w[1] ? data_q[1][idx] : data_q[0][idx];
   // A pending flush must be applied before anything is served, so a would-be hit stalls that cycle.
   assign hit_ok   = (state_q == IDLE) && hit && !flush_pending_q;
   assign victim   = !valid_q[0][idx] ? 1'b0 :
                     !valid_q[1][idx] ? 1'b1 : lru_q[idx];

   assign bus.busywait    = bus.read && !hit_ok;
   assign bus.readdata    = hit ? blk_sel[{woff, 5'd0} +: 32] : 32'd0;
   assign bus.mem_read    = mem_read_q;
   assign bus.mem_address = mem_addr_q;
   assign hit_count       = hit_count_q;
   assign miss_count      = miss_count_q;

   assign hit_count_d  = (hit_count_q  == {CNT_W{1'b1}}) ? hit_count_q  : hit_count_q  + CNT_W'(1);
   assign miss_count_d = (miss_count_q == {CNT_W{1'b1}}) ? miss_count_q : miss_count_q + CNT_W'(1);

   // Refill target comes from the latched block address: pc may move once read drops mid-refill.
   logic [INDEX_BITS-1:0] fill_idx;
   logic [TAG_W-1:0]      fill_tag;
   logic                  fill_en;
   assign fill_idx = mem_addr_q[INDEX_BITS-1:0];
   assign fill_tag = mem_addr_q[BADDR_W-1 -: TAG_W];
   assign fill_en  = (state_q == MEM_READ) && !bus.mem_busywait && !reset;

   // Control FSM and all reset state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= IDLE;
         valid_q[0]      <= '0;
         valid_q[1]      <= '0;
         lru_q           <= '0;
         victim_q        <= 1'b0;
         flush_pending_q <= 1'b0;
         mem_read_q      <= 1'b0;
         mem_addr_q      <= '0;
         hit_count_q     <= '0;
         miss_count_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!flush_pending_q && bus.read) begin
                  if (hit) begin
                     lru_q[idx]  <= ~hit_w[1];
                     hit_count_q <= hit_count_d;
                  end else begin
                     state_q      <= MEM_READ;
                     miss_count_q <= miss_count_d;
                     victim_q     <= victim;
                     mem_read_q   <= 1'b1;
                     mem_addr_q   <= {tag, idx};
                  end
               end
               // Flush overrides the LRU update above; a hit in this cycle is still served.
               if (flush || flush_pending_q) begin
                  valid_q[0]      <= '0;
                  valid_q[1]      <= '0;
                  lru_q           <= '0;
                  flush_pending_q <= 1'b0;
               end
            end
            MEM_READ: begin
               if (flush) flush_pending_q <= 1'b1;
               if (fill_en) begin
                  valid_q[victim_q][fill_idx] <= 1'b1;
                  lru_q[fill_idx]             <= ~victim_q;
                  mem_read_q                  <= 1'b0;
                  state_q                     <= C_UPDATE;
               end
            end
            C_UPDATE: begin
               if (flush) flush_pending_q <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Tag and data arrays carry no reset; valid bits qualify them.
   always_ff @(posedge clock) begin
      if (fill_en) begin
         data_q[victim_q][fill_idx] <= bus.mem_readdata;
         tag_q[victim_q][fill_idx]  <= fill_tag;
      end
   end
endmodule

// File: tb/tb_icache_2way.sv
// Directed bench for icache_2way: main instance (CNT_W=16) plus a CNT_W=2 instance for saturation.
// Memory model holds mem_busywait high for 'lat' cycles of mem_read, then returns block b with word w = 4*b+w+1.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_icache_2way;
   logic clock = 1'b0;
   logic reset;
   logic flush;
   logic s_flush;
   logic [15:0] hit_count, miss_count;
   logic [1:0]  s_hit, s_miss;

   always #5 clock = ~clock;

   icache_2way_if #(.ADDR_W(10), .WOFF_BITS(2)) bus ();
   icache_2way_if #(.ADDR_W(10), .WOFF_BITS(2)) sbus ();

   icache_2way #(.ADDR_W(10), .WOFF_BITS(2), .INDEX_BITS(2), .CNT_W(16)) u_dut (
      .clock(clock), .reset(reset), .flush(flush), .bus(bus.slave),
      .hit_count(hit_count), .miss_count(miss_count));

   icache_2way #(.ADDR_W(10), .WOFF_BITS(2), .INDEX_BITS(2), .CNT_W(2)) u_sat (
      .clock(clock), .reset(reset), .flush(s_flush), .bus(sbus.slave),
      .hit_count(s_hit), .miss_count(s_miss));

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- memory model for the main instance ----------------
   int lat = 4;
   int mem_cnt = 0;

   function automatic logic [127:0] blk(input logic [5:0] a);
      logic [127:0] b;
      for (int w = 0; w < 4; w++) b[w*32 +: 32] = 32'(a) * 4 + 32'(w) + 1;
      return b;
   endfunction

   initial begin
      bus.mem_busywait = 1'b1;
      bus.mem_readdata = '0;
      forever begin
         @(negedge clock);
         if (bus.mem_read) begin
            if (mem_cnt < lat) begin
               bus.mem_busywait = 1'b1;
               mem_cnt++;
            end else begin
               bus.mem_busywait = 1'b0;
               bus.mem_readdata = blk(bus.mem_address);
            end
         end else begin
            bus.mem_busywait = 1'b1;
            mem_cnt = 0;
         end
      end
   end

   // ---------------- access helpers ----------------
   int         mr_cyc;
   logic       addr_bad;
   logic [5:0] addr_seen;

   // One fetch: flush is pulsed in cycle flush_at of the access (-1 = never).
   task automatic do_access(input logic [9:0] pc, input int flush_at, input int exp_stall,
                            input logic [31:0] exp_data, input string tag);
      int stall;
      int cyc;
      @(posedge clock); #1;
      bus.read = 1'b1;
      bus.pc_address = pc;
      flush = (flush_at == 0);
      stall = 0; cyc = 0; mr_cyc = 0; addr_bad = 1'b0; addr_seen = '0;
      @(negedge clock);
      while (bus.busywait && stall < 100) begin
         if (bus.mem_read) begin
            if (mr_cyc == 0) addr_seen = bus.mem_address;
            else if (bus.mem_address != addr_seen) addr_bad = 1'b1;
            mr_cyc++;
         end
         stall++;
         @(posedge clock); #1;
         cyc++;
         flush = (cyc == flush_at);
         @(negedge clock);
      end
      check_val({tag, " stall"}, 128'(stall), 128'(exp_stall));
      check_val({tag, " data"}, 128'(bus.readdata), 128'(exp_data));
   endtask

   task automatic idle_cycle();
      @(posedge clock); #1;
      bus.read = 1'b0;
      flush = 1'b0;
      sbus.read = 1'b0;
      @(negedge clock);
   endtask

   task automatic sat_access(input logic [9:0] pc, input int exp_stall, input string tag);
      int stall;
      @(posedge clock); #1;
      sbus.read = 1'b1;
      sbus.pc_address = pc;
      stall = 0;
      @(negedge clock);
      while (sbus.busywait && stall < 100) begin
         stall++;
         @(negedge clock);
      end
      check_val({tag, " stall"}, 128'(stall), 128'(exp_stall));
      check_val({tag, " data"}, 128'(sbus.readdata), 128'h0000_0000_0000_0000_0000_0000_AAAA_0000);
   endtask

   initial begin
      #300000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   // ---------------- directed sequence ----------------
   initial begin
      reset = 1'b1; flush = 1'b0; s_flush = 1'b0;
      bus.read = 1'b0; bus.pc_address = '0;
      sbus.read = 1'b0; sbus.pc_address = '0;
      sbus.mem_busywait = 1'b0;
      sbus.mem_readdata = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check_val("rst busywait", 128'(bus.busywait), 128'd0);
      check_val("rst mem_read", 128'(bus.mem_read), 128'd0);
      check_val("rst mem_address", 128'(bus.mem_address), 128'd0);
      check_val("rst readdata", 128'(bus.readdata), 128'd0);
      check_val("rst hit_count", 128'(hit_count), 128'd0);
      check_val("rst miss_count", 128'(miss_count), 128'd0);

      // cold miss then same-block hits
      do_access(10'h000, -1, 7, 32'h1, "cold");
      check_val("cold mem_read cycles", 128'(mr_cyc), 128'd5);
      check_val("cold mem_address", 128'(addr_seen), 128'h00);
      check_val("cold addr stable", 128'(addr_bad), 128'd0);
      do_access(10'h004, -1, 0, 32'h2, "hit4");
      do_access(10'h008, -1, 0, 32'h3, "hit8");
      do_access(10'h00C, -1, 0, 32'h4, "hitC");
      check_val("hitC mem_read cycles", 128'(mr_cyc), 128'd0);
      idle_cycle();
      check_val("blk0 hit_count", 128'(hit_count), 128'd4);
      check_val("blk0 miss_count", 128'(miss_count), 128'd1);

      // LRU: 0x040 fills way1, 0x000 hit makes way1 LRU, 0x080 evicts 0x040
      do_access(10'h040, -1, 7, 32'h11, "fill40");
      do_access(10'h000, -1, 0, 32'h1, "lru hit0");
      do_access(10'h080, -1, 7, 32'h21, "fill80");
      do_access(10'h000, -1, 0, 32'h1, "keep0");
      check_val("keep0 mem_read cycles", 128'(mr_cyc), 128'd0);
      do_access(10'h040, -1, 7, 32'h11, "evicted40");
      check_val("evicted40 mem_address", 128'(addr_seen), 128'h04);
      idle_cycle();
      check_val("lru hit_count", 128'(hit_count), 128'd9);
      check_val("lru miss_count", 128'(miss_count), 128'd4);

      // flush in IDLE together with a hit: hit still served, then everything misses
      do_access(10'h000, 0, 0, 32'h1, "flush hit");
      do_access(10'h000, -1, 7, 32'h1, "post flush0");
      check_val("post flush0 mem_read cycles", 128'(mr_cyc), 128'd5);
      do_access(10'h040, -1, 7, 32'h11, "post flush40");
      idle_cycle();
      check_val("flush hit_count", 128'(hit_count), 128'd12);
      check_val("flush miss_count", 128'(miss_count), 128'd6);

      // flush during MEM_READ: refill, flush cycle, re-refill
      do_access(10'h0C0, 2, 15, 32'h31, "flush mid");
      check_val("flush mid mem_read cycles", 128'(mr_cyc), 128'd10);
      check_val("flush mid addr stable", 128'(addr_bad), 128'd0);
      do_access(10'h000, -1, 7, 32'h1, "after mid flush0");
      idle_cycle();
      check_val("mid hit_count", 128'(hit_count), 128'd14);
      check_val("mid miss_count", 128'(miss_count), 128'd9);

      // reset in the second MEM_READ cycle
      @(posedge clock); #1;
      bus.read = 1'b1; bus.pc_address = 10'h100;
      @(posedge clock); #1;
      @(posedge clock); #1;
      @(negedge clock);
      check_val("abort pre mem_read", 128'(bus.mem_read), 128'd1);
      check_val("abort pre mem_address", 128'(bus.mem_address), 128'h10);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      bus.read = 1'b0;
      @(negedge clock);
      check_val("abort mem_read", 128'(bus.mem_read), 128'd0);
      check_val("abort hit_count", 128'(hit_count), 128'd0);
      check_val("abort miss_count", 128'(miss_count), 128'd0);
      do_access(10'h100, -1, 7, 32'h41, "abort refetch");
      do_access(10'h000, -1, 7, 32'h1, "abort cleared0");
      idle_cycle();
      check_val("abort2 hit_count", 128'(hit_count), 128'd2);
      check_val("abort2 miss_count", 128'(miss_count), 128'd2);

      // saturation on the CNT_W=2 instance (memory answers immediately: stall 3)
      sat_access(10'h000, 3, "sat m0");
      idle_cycle();
      check_val("sat early hit", 128'(s_hit), 128'd1);
      check_val("sat early miss", 128'(s_miss), 128'd1);
      sat_access(10'h010, 3, "sat m1");
      sat_access(10'h020, 3, "sat m2");
      sat_access(10'h030, 3, "sat m3");
      sat_access(10'h000, 0, "sat h");
      idle_cycle();
      check_val("sat hit_count", 128'(s_hit), 128'd3);
      check_val("sat miss_count", 128'(s_miss), 128'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
